// File: rtl/uart_rx_control.sv
// uart_rx_control: oversampling 8N1 UART receiver with holding register, ready handshake and sticky error flags
module uart_rx_control #(
  parameter int word_size    = 8,
  parameter int clks_per_bit = 16
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic                 serial_in,
  input  logic                 data_read,
  output logic [word_size-1:0] rcv_data,
  output logic                 data_ready,
  output logic                 framing_err,
  output logic                 overrun_err
);
  localparam int cw = $clog2(clks_per_bit);
  localparam int iw = $clog2(word_size + 1);
  typedef enum logic [1:0] {idle, start, data, stop} state_t;
  state_t               r_state;
  logic [1:0]           r_sync;
  logic                 r_rx_d;
  logic [cw-1:0]        r_cnt;
  logic [iw-1:0]        r_idx;
  logic [word_size-1:0] r_sh;
  logic                 w_rx_s, w_half, w_full, w_stop, w_load;
  assign w_rx_s = r_sync[1];
  assign w_half = r_cnt == cw'(clks_per_bit / 2 - 1);
  assign w_full = r_cnt == cw'(clks_per_bit - 1);
  assign w_stop = r_state == stop && w_full;
  assign w_load = w_stop && w_rx_s && (!data_ready || data_read);
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) begin
      r_sync  <= 2'b11;
      r_rx_d  <= 1'b1;
      r_state <= idle;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_sh    <= '0;
    end else begin
      r_sync <= {r_sync[0], serial_in};
      r_rx_d <= w_rx_s;
      case (r_state)
        idle: begin
          r_cnt <= '0;
          if (r_rx_d && !w_rx_s) r_state <= start;
        end
        start: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_half) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_state <= w_rx_s ? idle : data;
          end
        end
        data: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_full) begin
            r_cnt <= '0;
            r_sh  <= {w_rx_s, r_sh[word_size-1:1]};
            r_idx <= r_idx + 1'b1;
            if (r_idx == iw'(word_size - 1)) r_state <= stop;
          end
        end
        stop: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_full) r_state <= idle;
        end
        default: r_state <= idle;
      endcase
    end
  // a load coinciding with data_read wins over the clear
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) begin
      rcv_data    <= '0;
      data_ready  <= 1'b0;
      framing_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      rcv_data    <= w_load ? r_sh : rcv_data;
      data_ready  <= w_load | (data_ready & ~data_read);
      framing_err <= (w_stop & ~w_rx_s) | (framing_err & ~data_read);
      overrun_err <= (w_stop & w_rx_s & data_ready & ~data_read) | (overrun_err & ~data_read);
    end
endmodule

// File: tb/tb_uart_rx_control.sv
// tb_uart_rx_control: directed and randomized frames checked against a frame-level receiver model
module tb_uart_rx_control;
  localparam int cpb = 16;
  logic       clk = 1'b0, rst_b = 1'b0, serial_in = 1'b1, data_read = 1'b0;
  logic [7:0] rcv_data;
  logic       data_ready, framing_err, overrun_err;
  int         tests = 0, fails = 0;
  logic [7:0] m_data = '0;
  logic       m_ready = 1'b0, m_fe = 1'b0, m_oe = 1'b0;
  logic [7:0] w;
  logic       sb, prev_bad;
  int         gap;
  uart_rx_control #(.word_size(8), .clks_per_bit(cpb)) dut (
    .clk(clk), .rst_b(rst_b), .serial_in(serial_in), .data_read(data_read),
    .rcv_data(rcv_data), .data_ready(data_ready), .framing_err(framing_err), .overrun_err(overrun_err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic check_all(input string tag);
    check({tag, ".data"}, 32'(rcv_data), 32'(m_data));
    check({tag, ".ready"}, 32'(data_ready), 32'(m_ready));
    check({tag, ".ferr"}, 32'(framing_err), 32'(m_fe));
    check({tag, ".oerr"}, 32'(overrun_err), 32'(m_oe));
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic idle_line(input int n);
    serial_in = 1'b1;
    tick(n);
  endtask
  task automatic drive_bits(input logic [9:0] bits, input int ncyc, output int rise);
    logic prev;
    prev = data_ready;
    rise = -1;
    for (int k = 0; k < ncyc; k++) begin
      serial_in = bits[k / cpb];
      tick(1);
      if (rise < 0 && data_ready && !prev) rise = k + 1;
      prev = data_ready;
    end
  endtask
  task automatic send_frame(input string tag, input logic [7:0] wd, input logic stop_bit);
    int rise;
    logic expect_rise;
    expect_rise = stop_bit && !m_ready;
    drive_bits({stop_bit, wd, 1'b0}, 10 * cpb, rise);
    if (expect_rise) begin
      tests++;
      assert (rise >= 154 && rise <= 156) else begin
        fails++;
        $error("FAIL %s.latency: got %0d expected 155+-1", tag, rise);
      end
    end
    if (!stop_bit) m_fe = 1'b1;
    else if (!m_ready) begin
      m_data  = wd;
      m_ready = 1'b1;
    end else m_oe = 1'b1;
  endtask
  task automatic read_pulse(input string tag);
    data_read = 1'b1;
    tick(1);
    data_read = 1'b0;
    m_ready = 1'b0;
    m_fe    = 1'b0;
    m_oe    = 1'b0;
    check({tag, ".ready_clr"}, 32'(data_ready), 32'(0));
  endtask
  initial begin
    int dummy;
    #23;
    check_all("reset");
    @(posedge clk);
    #1 rst_b = 1'b1;
    idle_line(5);
    send_frame("a5", 8'hA5, 1'b1);
    check_all("a5");
    read_pulse("rd_a5");
    send_frame("3c", 8'h3C, 1'b1);
    check_all("3c");
    read_pulse("rd_3c");
    send_frame("11", 8'h11, 1'b1);
    send_frame("22", 8'h22, 1'b1);
    check_all("overrun");
    read_pulse("rd_ovr");
    check_all("ovr_clr");
    send_frame("5a", 8'h5A, 1'b0);
    check_all("framing");
    serial_in = 1'b0;
    tick(3 * cpb);
    check_all("held_low");
    idle_line(4);
    send_frame("66", 8'h66, 1'b1);
    check_all("after_low");
    read_pulse("rd_66");
    idle_line(20);
    serial_in = 1'b0;
    tick(4);
    idle_line(cpb);
    check_all("glitch");
    send_frame("ff", 8'hFF, 1'b1);
    check_all("ff");
    drive_bits({1'b1, 8'h81, 1'b0}, 4 * cpb + cpb / 2, dummy);
    #2 rst_b = 1'b0;
    #1;
    m_data = '0; m_ready = 1'b0; m_fe = 1'b0; m_oe = 1'b0;
    check_all("async_rst");
    serial_in = 1'b1;
    tick(3);
    rst_b = 1'b1;
    idle_line(3 * cpb);
    check_all("post_rst");
    send_frame("81", 8'h81, 1'b1);
    check_all("81");
    prev_bad = 1'b0;
    for (int i = 0; i < 24; i++) begin
      w  = 8'($urandom);
      sb = $urandom_range(0, 4) != 0;
      if ($urandom_range(0, 1) == 1) read_pulse("rnd_rd");
      send_frame("rnd", w, sb);
      check_all("rnd");
      gap = prev_bad ? 0 : 0;
      gap = sb ? $urandom_range(0, 20) : $urandom_range(2, 20);
      prev_bad = !sb;
      idle_line(gap);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
